// File: rtl/load_data_queue_mp.sv
// load_data_queue_mp
// Multi-ported load data queue. Up to DISP_WIDTH loads are allocated per cycle
// in program order, and up to EXEC_WIDTH address writebacks are accepted per cycle.
// The oldest load that has its address and whose older stores have drained is
// issued. Issued entries retire in order from the head. A branch flush rolls the
// tail back to the squash point.
module load_data_queue_mp #(
   parameter int LDQ_ENTRIES = 16,
   parameter int SDQ_ENTRIES = 16,
   parameter int DISP_WIDTH  = 2,
   parameter int EXEC_WIDTH  = 2,
   parameter int FREE_WIDTH  = 2,
   parameter int ADDR_W      = 32,
   localparam int IDX_W      = $clog2(LDQ_ENTRIES),
   localparam int SM_W       = $clog2(SDQ_ENTRIES) + 1,
   localparam int PTR_W      = IDX_W + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DISP_WIDTH-1:0]        disp_vld,
   input  logic [DISP_WIDTH*SM_W-1:0]   disp_sdq_marker,
   output logic [DISP_WIDTH*IDX_W-1:0]  disp_ldq_idx,
   output logic                         disp_full,
   input  logic [EXEC_WIDTH-1:0]        exec_vld,
   input  logic [EXEC_WIDTH*IDX_W-1:0]  exec_ldq_idx,
   input  logic [EXEC_WIDTH*ADDR_W-1:0] exec_addr,
   input  logic [SM_W-1:0]              sdq_head_ptr,
   output logic                         issue_vld,
   input  logic                         issue_rdy,
   output logic [IDX_W-1:0]             issue_ldq_idx,
   output logic [ADDR_W-1:0]            issue_addr,
   input  logic                         flush_vld,
   input  logic [IDX_W-1:0]             flush_ldq_idx,
   output logic [IDX_W:0]               count
);

   // Queue pointers carry a wrap bit above the index so full and empty differ
   logic [PTR_W-1:0]       head_q, tail_q;
   logic [PTR_W-1:0]       head_nxt, tail_nxt;
   logic [IDX_W-1:0]       head_idx, tail_idx;

   // Per-entry control flags
   logic [LDQ_ENTRIES-1:0] valid_q, addr_vld_q, st_clear_q, issued_q;
   logic [LDQ_ENTRIES-1:0] valid_nxt, addr_vld_nxt, st_clear_nxt, issued_nxt;

   // Per-entry payload (not reset; only meaningful while the entry is valid)
   logic [SM_W-1:0]        marker_q [LDQ_ENTRIES];
   logic [ADDR_W-1:0]      addr_q   [LDQ_ENTRIES];

   // Per-entry write strobes and write data
   logic [LDQ_ENTRIES-1:0] alloc;
   logic [LDQ_ENTRIES-1:0] exec_hit;
   logic [LDQ_ENTRIES-1:0] squash;
   logic [SM_W-1:0]        alloc_marker [LDQ_ENTRIES];
   logic [ADDR_W-1:0]      exec_wdata   [LDQ_ENTRIES];

   // Dispatch / free / issue bookkeeping
   logic                   disp_ok;
   logic [PTR_W-1:0]       disp_cnt;
   logic [IDX_W-1:0]       lane_idx;
   logic [PTR_W-1:0]       nfree;
   logic                   free_stop;
   logic [IDX_W-1:0]       free_idx;
   logic [IDX_W-1:0]       flush_dist;
   logic                   sel_found;
   logic [IDX_W-1:0]       sel_idx;
   logic [IDX_W-1:0]       cand_idx;
   logic                   issue_fire;

   // Age of an entry measured as its distance from the head slot
   function automatic logic [IDX_W-1:0] age_of(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] base);
      return idx - base;
   endfunction

   assign head_idx   = head_q[IDX_W-1:0];
   assign tail_idx   = tail_q[IDX_W-1:0];
   assign count      = tail_q - head_q;
   assign disp_full  = (LDQ_ENTRIES - int'(count)) < DISP_WIDTH;
   assign disp_ok    = !disp_full && !flush_vld;
   assign flush_dist = age_of(flush_ldq_idx, head_idx);

   // Lane index allocation: each valid lane takes the next slot after older valid lanes
   always_comb begin
      disp_ldq_idx = '0;
      disp_cnt     = '0;
      lane_idx     = '0;
      alloc        = '0;
      for (int j = 0; j < LDQ_ENTRIES; j++) begin
         alloc_marker[j] = '0;
      end
      for (int i = 0; i < DISP_WIDTH; i++) begin
         lane_idx = tail_idx + disp_cnt[IDX_W-1:0];
         if (disp_vld[i]) begin
            disp_ldq_idx[i*IDX_W +: IDX_W] = lane_idx;
            if (disp_ok) begin
               alloc[lane_idx]        = 1'b1;
               alloc_marker[lane_idx] = disp_sdq_marker[i*SM_W +: SM_W];
            end
            disp_cnt = disp_cnt + PTR_W'(1);
         end
      end
   end

   // In-order free: count the leading run of issued entries at the head,
   // stopping at the squash point so a flushed entry is never also freed
   always_comb begin
      nfree     = '0;
      free_stop = 1'b0;
      free_idx  = '0;
      for (int k = 0; k < FREE_WIDTH; k++) begin
         free_idx = head_idx + IDX_W'(k);
         if (!free_stop && valid_q[free_idx] && issued_q[free_idx] &&
             (!flush_vld || (IDX_W'(k) < flush_dist))) begin
            nfree = nfree + PTR_W'(1);
         end else begin
            free_stop = 1'b1;
         end
      end
   end

   // Oldest-ready select, scanning from the head; registered state only
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand_idx  = '0;
      for (int k = 0; k < LDQ_ENTRIES; k++) begin
         cand_idx = head_idx + IDX_W'(k);
         if (!sel_found && valid_q[cand_idx] && addr_vld_q[cand_idx] &&
             st_clear_q[cand_idx] && !issued_q[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   assign issue_vld     = sel_found;
   assign issue_ldq_idx = sel_idx;
   assign issue_addr    = sel_found ? addr_q[sel_idx] : '0;
   assign issue_fire    = issue_vld && issue_rdy;

   // Per-entry next state: squash/free clear first, then allocation, then updates
   always_comb begin
      valid_nxt    = '0;
      addr_vld_nxt = '0;
      st_clear_nxt = '0;
      issued_nxt   = '0;
      squash       = '0;
      exec_hit     = '0;
      for (int j = 0; j < LDQ_ENTRIES; j++) begin
         exec_wdata[j] = '0;
      end
      for (int j = 0; j < LDQ_ENTRIES; j++) begin
         squash[j] = flush_vld && (age_of(IDX_W'(j), head_idx) >= flush_dist);
         // Ascending port scan so the highest-numbered port wins on duplicates
         for (int p = 0; p < EXEC_WIDTH; p++) begin
            if (exec_vld[p] && (exec_ldq_idx[p*IDX_W +: IDX_W] == IDX_W'(j)) &&
                valid_q[j] && !squash[j]) begin
               exec_hit[j]   = 1'b1;
               exec_wdata[j] = exec_addr[p*ADDR_W +: ADDR_W];
            end
         end
         if (squash[j] || ({1'b0, age_of(IDX_W'(j), head_idx)} < nfree)) begin
            valid_nxt[j]    = 1'b0;
            addr_vld_nxt[j] = 1'b0;
            st_clear_nxt[j] = 1'b0;
            issued_nxt[j]   = 1'b0;
         end else if (alloc[j]) begin
            valid_nxt[j]    = 1'b1;
            addr_vld_nxt[j] = 1'b0;
            st_clear_nxt[j] = (alloc_marker[j] == sdq_head_ptr);
            issued_nxt[j]   = 1'b0;
         end else if (valid_q[j]) begin
            valid_nxt[j]    = 1'b1;
            addr_vld_nxt[j] = addr_vld_q[j] | exec_hit[j];
            st_clear_nxt[j] = st_clear_q[j] | (marker_q[j] == sdq_head_ptr);
            issued_nxt[j]   = issued_q[j] | (issue_fire && (sel_idx == IDX_W'(j)));
         end
      end
   end

   // Pointer update: flush rebuilds tail from head so the wrap bit stays consistent
   always_comb begin
      head_nxt = head_q + nfree;
      if (flush_vld) begin
         tail_nxt = head_q + {1'b0, flush_dist};
      end else if (disp_ok) begin
         tail_nxt = tail_q + disp_cnt;
      end else begin
         tail_nxt = tail_q;
      end
   end

   // Control state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         valid_q    <= '0;
         addr_vld_q <= '0;
         st_clear_q <= '0;
         issued_q   <= '0;
      end else begin
         head_q     <= head_nxt;
         tail_q     <= tail_nxt;
         valid_q    <= valid_nxt;
         addr_vld_q <= addr_vld_nxt;
         st_clear_q <= st_clear_nxt;
         issued_q   <= issued_nxt;
      end
   end

   // Payload storage: marker written at allocation, address at accepted writeback
   always_ff @(posedge clk) begin
      for (int j = 0; j < LDQ_ENTRIES; j++) begin
         if (alloc[j]) begin
            marker_q[j] <= alloc_marker[j];
         end
         if (exec_hit[j]) begin
            addr_q[j] <= exec_wdata[j];
         end
      end
   end

endmodule

// File: doc/load_data_queue_mp.md
Name: load_data_queue_mp

Overview:
- Parametrised, multi-ported successor to the single-port load data queue in the load/store unit.
- Allocates up to DISP_WIDTH loads per cycle in program order and accepts up to EXEC_WIDTH address writebacks per cycle.
- Issues the oldest load whose address is known and whose older stores have drained (store-queue marker), and frees issued entries in order from the head.
- Supports branch-flush rollback of the tail pointer.

Parameters:
- LDQ_ENTRIES, 16: queue depth; power of two, at least 4.
- SDQ_ENTRIES, 16: store data queue depth; sets the marker width SM_W = clog2(SDQ_ENTRIES)+1, which includes a wrap bit.
- DISP_WIDTH, 2: dispatch lanes per cycle.
- EXEC_WIDTH, 2: address writeback ports per cycle.
- FREE_WIDTH, 2: maximum head entries freed per cycle.
- ADDR_W, 32: address width.
- Derived: IDX_W = clog2(LDQ_ENTRIES).

Ports:
- clk, input, 1: single clock; all state changes on rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- disp_vld, input, DISP_WIDTH: per-lane dispatch request; lanes are in program order, lane 0 oldest.
- disp_sdq_marker, input, DISP_WIDTH*SM_W: SDQ tail pointer (with wrap bit) at dispatch, per lane.
- disp_ldq_idx, output, DISP_WIDTH*IDX_W: index allocated to each valid lane.
- disp_full, output, 1: fewer than DISP_WIDTH free entries.
- exec_vld, input, EXEC_WIDTH: address writeback valid.
- exec_ldq_idx, input, EXEC_WIDTH*IDX_W: target entry.
- exec_addr, input, EXEC_WIDTH*ADDR_W: computed load address.
- sdq_head_ptr, input, SM_W: SDQ retire pointer with wrap bit.
- issue_vld, output, 1: an entry is ready to issue.
- issue_rdy, input, 1: downstream accepts the issue.
- issue_ldq_idx, output, IDX_W: index of the issuing entry.
- issue_addr, output, ADDR_W: address of the issuing entry.
- flush_vld, input, 1: branch flush.
- flush_ldq_idx, input, IDX_W: first entry to squash; it and all younger entries are squashed.
- count, output, IDX_W+1: number of occupied entries.

Behaviour:
- State:
  - head and tail pointers, each IDX_W+1 bits with wrap bit.
  - Per entry: valid, addr_vld, st_clear, issued, marker[SM_W], addr[ADDR_W].
- Reset (rst low, asynchronous):
  - head = tail = 0; all per-entry flags cleared.
  - Outputs: disp_full=0, issue_vld=0, issue_ldq_idx=0, issue_addr=0, count=0, disp_ldq_idx=0.
- Occupancy and full:
  - count = tail - head, modulo 2^(IDX_W+1).
  - disp_full = (LDQ_ENTRIES - count) < DISP_WIDTH; combinational from registered state.
- Dispatch:
  - Ignored entirely when disp_full=1 or flush_vld=1 in that cycle.
  - Otherwise lane i receives index tail + popcount(disp_vld[i-1:0]); disp_ldq_idx is combinational in the same cycle.
  - On the edge, each allocated entry gets valid=1, addr_vld=0, issued=0, and its marker stored.
  - st_clear is set at dispatch if marker == sdq_head_ptr.
  - tail advances by popcount(disp_vld). Non-contiguous lane patterns are legal.
- Store clearance:
  - Each cycle, any valid entry with marker == sdq_head_ptr sets st_clear.
  - st_clear is sticky until the entry is freed.
- Exec writeback:
  - For each port with exec_vld and a target entry that is valid: set addr_vld and write addr.
  - Writes to invalid entries (including entries squashed in the same cycle) are dropped.
  - Duplicate indices across ports in one cycle: the highest-numbered port wins.
  - A rewrite to an entry that already has addr_vld overwrites the address; issued is unchanged.
- Issue select:
  - Among valid, addr_vld, st_clear, !issued entries, select the oldest by distance from head.
  - issue_vld, issue_ldq_idx and issue_addr are driven combinationally from registered state; the select is on state only, with no bypass from same-cycle exec or dispatch.
  - On issue_vld & issue_rdy, set issued on the selected entry.
  - Out-of-order issue is allowed: a younger ready entry issues past an older unready one.
- Free:
  - Starting at head, up to FREE_WIDTH consecutive entries with valid & issued are cleared per cycle and head advances.
  - An entry issued in cycle N is freed no earlier than cycle N+1.
- Flush:
  - tail is set to flush_ldq_idx, keeping the wrap bit consistent with head.
  - Entries from flush_ldq_idx up to the old tail are cleared.
  - flush_ldq_idx == head.idx with count>0 empties the queue.
  - Flush has priority over dispatch and exec for squashed entries.
  - An issue handshake in the same cycle on a squashed entry is dropped; the entry is not freed.
- Simultaneous dispatch and free in one cycle are both applied; count changes by the net amount.
- Wrap-around: pointer arithmetic is modulo; full is tail.idx == head.idx with wrap bits differing.

Test Plan:
- Reset, then dispatch lanes 0 and 1 with marker 5 while sdq_head_ptr=5 -> disp_ldq_idx 0,1; count=2; both entries st_clear.
- Exec idx1 addr 0x100, then idx0 addr 0x200, issue_rdy=1 -> idx1 issues first; idx0 issues next cycle; head reaches 2 one cycle after idx0 issues; count=0.
- Fill 16 entries (8 dual dispatches) -> disp_full=1 at count 15 and 16; a 9th dispatch is ignored and tail is unchanged; drain all entries, then dispatch again -> wrap index 0 with wrap bit set.
- Dispatch with marker 7 while sdq_head_ptr=3, address valid -> issue_vld stays 0; step sdq_head_ptr to 7 -> issue_vld=1 on the next cycle and stays asserted after sdq_head_ptr moves to 8.
- With 6 entries occupied, flush_ldq_idx=3 together with a dispatch and an exec to idx4 -> count=3; dispatch ignored; idx4 stays invalid; next dispatch gets idx 3.
- Assert rst mid-stream with issue_vld=1 -> all outputs clear immediately without waiting for a clock edge; after release the first dispatch gets idx 0.
